btn_debouncer: RTL and testbench

BTN_DEBOUNCER -- requirements
Module: btn_debouncer

---
 rtl/btn_debouncer.sv | 140 ++++++++++++++
 tb/tb_btn_debouncer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/btn_debouncer.sv
// rtl/btn_debouncer.sv - four-button synchronizer, debouncer and press/release/multi-press tracker
module btn_debouncer #(
   parameter int STABLE_CYCLES = 500000,
   parameter int CNT_W         = 19
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] btns,
   output logic [1:0] num,
   output logic       pressed,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       multi
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      INVALID = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [3:0]       r_sync1;
   logic [3:0]       r_sync2;
   logic [3:0]       r_cand;
   logic [3:0]       r_deb;
   logic [CNT_W-1:0] r_cnt;
   state_t           r_state;
   logic [1:0]       r_num;
   logic             r_pressed;
   logic             r_press_pulse;
   logic             r_release_pulse;
   logic             r_multi;

   state_t           w_next_state;
   logic [1:0]       w_next_num;
   logic             w_press;
   logic             w_release;
   logic             w_onehot;
   logic [1:0]       w_idx;
   logic [3:0]       w_num_mask;

   // Input path: synchronizer, then a candidate that must stay unchanged for STABLE_CYCLES
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= 4'd0;
         r_sync2 <= 4'd0;
         r_cand  <= 4'd0;
         r_cnt   <= '0;
         r_deb   <= 4'd0;
      end else begin
         r_sync1 <= btns;
         r_sync2 <= r_sync1;
         if (r_sync2 != r_cand) begin
            r_cand <= r_sync2;
            r_cnt  <= '0;
         end else begin
            if (r_cnt != CNT_MAX) begin
               r_cnt <= r_cnt + CNT_ONE;
            end
            if ((r_cnt == CNT_MAX) && (r_cand != r_deb)) begin
               r_deb <= r_cand;
            end
         end
      end
   end

   assign w_onehot   = (r_deb != 4'd0) && ((r_deb & (r_deb - 4'd1)) == 4'd0);
   assign w_num_mask = 4'd1 << r_num;

   always_comb begin
      w_idx = 2'd0;
      for (int k = 0; k < 4; k++) begin
         if (r_deb[k]) begin
            w_idx = 2'(k);
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_next_num   = r_num;
      w_press      = 1'b0;
      w_release    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_onehot) begin
               w_next_state = PRESSED;
               w_next_num   = w_idx;
               w_press      = 1'b1;
            end else if (r_deb != 4'd0) begin
               w_next_state = INVALID;
            end
         end
         PRESSED: begin
            if (r_deb == 4'd0) begin
               w_next_state = IDLE;
               w_release    = 1'b1;
            end else if (r_deb != w_num_mask) begin
               w_next_state = INVALID;
               w_release    = 1'b1;
            end
         end
         INVALID: begin
            // Every button must be released before another press can be accepted
            if (r_deb == 4'd0) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= IDLE;
         r_num           <= 2'd0;
         r_pressed       <= 1'b0;
         r_press_pulse   <= 1'b0;
         r_release_pulse <= 1'b0;
         r_multi         <= 1'b0;
      end else begin
         r_state         <= w_next_state;
         r_num           <= w_next_num;
         r_pressed       <= (w_next_state == PRESSED);
         r_press_pulse   <= w_press;
         r_release_pulse <= w_release;
         r_multi         <= (w_next_state == INVALID);
      end
   end

   assign num           = r_num;
   assign pressed       = r_pressed;
   assign press_pulse   = r_press_pulse;
   assign release_pulse = r_release_pulse;
   assign multi         = r_multi;

endmodule

// File: tb/tb_btn_debouncer.sv
// tb/tb_btn_debouncer.sv - table-driven scoreboard bench for btn_debouncer with STABLE_CYCLES = 4
module tb_btn_debouncer;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] btns;
   logic [1:0] num;
   logic       pressed;
   logic       press_pulse;
   logic       release_pulse;
   logic       multi;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   localparam int LAT = 8;

   btn_debouncer #(.STABLE_CYCLES(4), .CNT_W(3)) dut (
      .clk           (clk),
      .reset         (reset),
      .btns          (btns),
      .num           (num),
      .pressed       (pressed),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .multi         (multi)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [3:0] b;
      int         hold;
      bit         ev;
      bit         rel;
      logic [1:0] n;
      bit         ev_multi;
      bit         end_pressed;
      bit         end_multi;
   } vec_t;

   typedef struct {
      bit         rel;
      int         at;
      logic [1:0] n;
      bit         mu;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   task automatic check(input string name, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] b, input int hold, input bit ev, input bit rel,
                               input logic [1:0] n, input bit ev_multi, input bit ep, input bit em);
      vec_t v;
      v.b = b; v.hold = hold; v.ev = ev; v.rel = rel; v.n = n;
      v.ev_multi = ev_multi; v.end_pressed = ep; v.end_multi = em;
      return v;
   endfunction

   task automatic push_ev(input bit rel, input logic [1:0] n, input bit mu);
      exp_t e;
      e.rel = rel; e.at = cyc + LAT; e.n = n; e.mu = mu;
      sb.push_back(e);
   endtask

   // Monitor: every pulse must match the head of the scoreboard; pulses never overlap or stretch
   logic prev_press = 1'b0;
   logic prev_release = 1'b0;
   always @(negedge clk) begin
      if (reset !== 1'b1) begin
         check("pulses_exclusive", int'(press_pulse & release_pulse), 0);
         if (press_pulse)   check("press_pulse_width", int'(prev_press), 0);
         if (release_pulse) check("release_pulse_width", int'(prev_release), 0);
         if (press_pulse || release_pulse) begin
            if (sb.size() == 0) begin
               check("unexpected_pulse", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("pulse_kind_release", int'(release_pulse), int'(e.rel));
               check("pulse_cycle", cyc, e.at);
               check("pulse_num", int'(num), int'(e.n));
               check("pulse_pressed", int'(pressed), int'(!e.rel));
               check("pulse_multi", int'(multi), int'(e.mu));
            end
         end
      end
      prev_press   <= press_pulse;
      prev_release <= release_pulse;
   end

   initial begin
      // Clean press/release, bounce, multi-press, recovery, slide
      vecs.push_back(mk(4'b0100, 12, 1, 0, 2'd2, 0, 1, 0));
      vecs.push_back(mk(4'b0000, 12, 1, 1, 2'd2, 0, 0, 0));
      for (int i = 0; i < 10; i++)
         vecs.push_back(mk((i % 2 == 0) ? 4'b0001 : 4'b0000, 2, 0, 0, 2'd0, 0, 0, 0));
      vecs.push_back(mk(4'b0001, 12, 1, 0, 2'd0, 0, 1, 0));
      vecs.push_back(mk(4'b0000, 12, 1, 1, 2'd0, 0, 0, 0));
      vecs.push_back(mk(4'b0011, 12, 0, 0, 2'd0, 0, 0, 1));
      vecs.push_back(mk(4'b0010, 12, 0, 0, 2'd0, 0, 0, 1));
      vecs.push_back(mk(4'b0000, 12, 0, 0, 2'd0, 0, 0, 0));
      vecs.push_back(mk(4'b1000, 12, 1, 0, 2'd3, 0, 1, 0));
      vecs.push_back(mk(4'b0000, 12, 1, 1, 2'd3, 0, 0, 0));
      vecs.push_back(mk(4'b0010, 12, 1, 0, 2'd1, 0, 1, 0));
      vecs.push_back(mk(4'b0100, 12, 1, 1, 2'd1, 1, 0, 1));
      vecs.push_back(mk(4'b0000, 12, 0, 0, 2'd1, 0, 0, 0));

      reset = 1'b1;
      btns  = 4'b0000;
      repeat (3) @(negedge clk);
      check("rst_num", int'(num), 0);
      check("rst_pressed", int'(pressed), 0);
      check("rst_press_pulse", int'(press_pulse), 0);
      check("rst_release_pulse", int'(release_pulse), 0);
      check("rst_multi", int'(multi), 0);
      reset = 1'b0;

      foreach (vecs[i]) begin
         btns = vecs[i].b;
         if (vecs[i].ev) push_ev(vecs[i].rel, vecs[i].n, vecs[i].ev_multi);
         repeat (vecs[i].hold) @(negedge clk);
         check($sformatf("vec%0d_pressed", i), int'(pressed), int'(vecs[i].end_pressed));
         check($sformatf("vec%0d_multi", i), int'(multi), int'(vecs[i].end_multi));
         if (vecs[i].end_pressed || vecs[i].ev)
            check($sformatf("vec%0d_num", i), int'(num), int'(vecs[i].n));
      end

      // Reset while pressed: outputs clear, held button re-reported without a release
      btns = 4'b1000;
      push_ev(0, 2'd3, 0);
      repeat (12) @(negedge clk);
      check("pre_reset_pressed", int'(pressed), 1);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_num", int'(num), 0);
      check("midrst_pressed", int'(pressed), 0);
      check("midrst_press_pulse", int'(press_pulse), 0);
      check("midrst_release_pulse", int'(release_pulse), 0);
      check("midrst_multi", int'(multi), 0);
      reset = 1'b0;
      push_ev(0, 2'd3, 0);
      repeat (12) @(negedge clk);
      check("post_reset_pressed", int'(pressed), 1);
      check("post_reset_num", int'(num), 3);
      btns = 4'b0000;
      push_ev(1, 2'd3, 0);
      repeat (12) @(negedge clk);
      check("final_pressed", int'(pressed), 0);
      check("final_num", int'(num), 3);

      check("scoreboard_pending", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
